// File: rtl/zbb_pkg.sv
// Shared definitions for the Zbb bit-count sequencer.
// Holds the op encoding, the FSM state type and the default count width.
package zbb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CHUNK_DEF = 8;
    localparam int CNT_W     = $clog2(XLEN_DEF) + 1;

    localparam logic [1:0] OP_CLZ  = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;   // decoded as cpop

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/zbb_chunk_cnt.sv
// Combinational per-chunk counter shared by clz, ctz and cpop.
// Ports:
//   din : CHUNK-bit slice of the operand, MSB first
//   lz  : number of leading zeros, CHUNK when din is all zero
//   pop : number of set bits
module zbb_chunk_cnt #(
    parameter int CHUNK = 8,
    localparam int CW   = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] din,
    output logic [CW-1:0]    lz,
    output logic [CW-1:0]    pop
);

    logic found;

    always_comb begin
        lz    = CW'(CHUNK);
        found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                lz    = CW'(CHUNK - 1 - i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + CW'(din[i]);
        end
    end

endmodule

// File: rtl/zbb_bitcnt_seq.sv
// Iterative clz/ctz/cpop sequencer. Scans the operand CHUNK bits per cycle
// from the MSB end; ctz is turned into clz by bit-reversing the operand on
// accept. clz/ctz stop at the first nonzero chunk, cpop scans every chunk.
//
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   valid_i / ready_o  : request handshake (op_i, operand_i)
//   flush_i            : synchronous kill, wins over accept and result handshake
//   valid_o / ready_i  : result handshake (result_o, zero-extended count)
//   busy_o             : high while scanning or holding a result
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for a request, ready_o high
// SCAN    | one chunk accumulated per cycle
// DONE    | result presented, held until ready_i
module zbb_bitcnt_seq
    import zbb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(XLEN) + 1;
    localparam int LW     = $clog2(CHUNK) + 1;

    state_t          state_q, state_d;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] opnd_rev;
    logic            cpop_q;
    logic [CW-1:0]   cnt_q;
    logic [KW-1:0]   k_q;

    logic [CHUNK-1:0] chunk;
    logic [LW-1:0]    chunk_lz;
    logic [LW-1:0]    chunk_pop;
    logic             last_chunk;
    logic             scan_end;

    always_comb begin
        opnd_rev = '0;
        for (int i = 0; i < XLEN; i++) begin
            opnd_rev[i] = operand_i[XLEN-1-i];
        end
    end

    // The operand register shifts left each scan cycle, so the chunk under
    // inspection is always the top CHUNK bits (chunk k of the latched value).
    assign chunk = opnd_q[XLEN-1 -: CHUNK];

    zbb_chunk_cnt #(.CHUNK(CHUNK)) u_chunk_cnt (
        .din (chunk),
        .lz  (chunk_lz),
        .pop (chunk_pop)
    );

    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    assign scan_end   = last_chunk || (!cpop_q && (chunk != '0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (valid_i) state_d = ST_SCAN;
            ST_SCAN: if (scan_end) state_d = ST_DONE;
            ST_DONE: if (ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            cpop_q  <= 1'b0;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                cnt_q <= '0;
                k_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid_i) begin
                            opnd_q <= (op_i == OP_CTZ) ? opnd_rev : operand_i;
                            cpop_q <= op_i[1];
                            cnt_q  <= '0;
                            k_q    <= '0;
                        end
                    end
                    ST_SCAN: begin
                        cnt_q  <= cnt_q + (cpop_q ? CW'(chunk_pop) : CW'(chunk_lz));
                        opnd_q <= opnd_q << CHUNK;
                        if (!scan_end) k_q <= k_q + KW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign busy_o   = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign result_o = (state_q == ST_DONE) ? XLEN'(cnt_q) : '0;

endmodule

// File: tb/tb_zbb_bitcnt_seq.sv
module tb_zbb_bitcnt_seq;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] operand_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    zbb_bitcnt_seq #(.XLEN(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .operand_i (operand_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
        return 32;
    endfunction

    function automatic int ref_ctz(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 32;
    endfunction

    function automatic int ref_pop(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int ref_result(input logic [1:0] op, input logic [31:0] v);
        if (op[1]) return ref_pop(v);
        return (op == 2'b00) ? ref_clz(v) : ref_ctz(v);
    endfunction

    // Accept edge counted as 1; one extra cycle on top of the chunks read.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] v);
        int z, scanned;
        if (op[1]) return 32 / 8 + 1;
        z = ref_result(op, v);
        scanned = z / 8 + 1;
        if (scanned > 4) scanned = 4;
        return scanned + 1;
    endfunction

    task automatic wait_valid(output int n);
        n = 1;
        while (!valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] v, input int stall);
        int n;
        int exp_res = ref_result(op, v);
        int exp_lat = ref_latency(op, v);
        @(negedge clk);
        chk("ready_idle", 32'(ready_o), 32'd1);
        valid_i   = 1'b1;
        op_i      = op;
        operand_i = v;
        ready_i   = (stall == 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        wait_valid(n);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("result", result_o, 32'(exp_res));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_result", result_o, 32'(exp_res));
            chk("hold_ready_o", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", 32'(valid_o), 32'd0);
        chk("back_idle", 32'(ready_o), 32'd1);
        chk("result_zero", result_o, 32'd0);
    endtask

    initial begin
        int n;
        logic [1:0]  op;
        logic [31:0] v;

        rst_n = 1'b0; valid_i = 1'b0; op_i = 2'b00; operand_i = '0;
        flush_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        chk("rst_result_o", result_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // directed
        do_op(2'b00, 32'h0001_0000, 0);
        do_op(2'b01, 32'h8000_0000, 0);
        do_op(2'b01, 32'h0000_0001, 0);
        do_op(2'b00, 32'h0000_0000, 0);
        do_op(2'b01, 32'h0000_0000, 0);
        do_op(2'b10, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'h8000_0001, 0);
        do_op(2'b11, 32'h0F0F_0F0F, 0);
        do_op(2'b00, 32'h0000_00FF, 3);

        // flush during SCAN
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b10; operand_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_scan_ready", 32'(ready_o), 32'd1);
        chk("flush_scan_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_scan_no_valid", 32'(valid_o), 32'd0);
            @(posedge clk); #1;
        end

        // flush during DONE, with a request presented in the same cycle
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1; op_i = 2'b00; operand_i = 32'h0001_0000;
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_valid(n);
        chk("flush_done_reached", 32'(valid_o), 32'd1);
        flush_i = 1'b1; valid_i = 1'b1; op_i = 2'b10; operand_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        chk("flush_done_valid", 32'(valid_o), 32'd0);
        chk("flush_done_not_accepted", 32'(ready_o), 32'd1);
        chk("flush_done_busy", 32'(busy_o), 32'd0);
        do_op(2'b00, 32'h1000_0000, 0);

        // reset mid-SCAN
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b10; operand_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_o", 32'(ready_o), 32'd1);
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_busy_o", 32'(busy_o), 32'd0);
        chk("midrst_result_o", result_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_valid_o", 32'(valid_o), 32'd0);
        do_op(2'b01, 32'h0000_0100, 0);

        // randomized
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            v  = $urandom;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 2) == 0) v[c*8 +: 8] = 8'h00;
            end
            if ($urandom_range(0, 4) == 0) v = 32'd1 << $urandom_range(0, 31);
            do_op(op, v, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
